// File: rtl/fibonacci_unit_if.sv
// Start/done handshake bundle for fibonacci_unit.
// The controller drives the index and the start pulse; the unit returns
// the result and its valid level.
interface fibonacci_unit_if;
  logic [15:0] din;
  logic        start;
  logic [15:0] dout;
  logic        done;

  modport master (
    output din,
    output start,
    input  dout,
    input  done
  );

  modport slave (
    input  din,
    input  start,
    output dout,
    output done
  );
endinterface

// File: rtl/fibonacci_unit.sv
// Iterative 16-bit Fibonacci calculator.
// A start pulse captures the index, and the unit takes one recurrence step per clock.
// The result is then presented on dout with done held high until the next accepted start.
// Optional feature macro: FIB_SATURATE_EN. When it is defined, a result whose
// true value exceeds 16 bits is reported as 16'hFFFF. When it is undefined,
// the result is the plain modulo-2^16 value.
module fibonacci_unit (
  input  logic               clk,
  input  logic               reset,
  fibonacci_unit_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      next_state_s;
  logic [15:0] a_r;
  logic [15:0] b_r;
  logic [15:0] cnt_r;
  logic [15:0] dout_r;
  logic        done_r;
  logic [15:0] a_nxt_s;
  logic [15:0] b_nxt_s;
  logic [15:0] cnt_nxt_s;
  logic [15:0] dout_nxt_s;
  logic        done_nxt_s;
  logic [16:0] sum_s;
  logic [15:0] result_s;

`ifdef FIB_SATURATE_EN
  logic a_sat_r;
  logic b_sat_r;
  logic a_sat_nxt_s;
  logic b_sat_nxt_s;
`endif

  // Carry-out is kept so the saturating build can see when a+b overflows.
  assign sum_s = {1'b0, a_r} + {1'b0, b_r};

`ifdef FIB_SATURATE_EN
  assign result_s = a_sat_r ? 16'hFFFF : a_r;
`else
  assign result_s = a_r;
`endif

  assign bus.dout = dout_r;
  assign bus.done = done_r;

  // Next-state and datapath update for the IDLE/CALC/DONE sequencer.
  always_comb begin
    next_state_s = state_r;
    a_nxt_s      = a_r;
    b_nxt_s      = b_r;
    cnt_nxt_s    = cnt_r;
    dout_nxt_s   = dout_r;
    done_nxt_s   = done_r;
`ifdef FIB_SATURATE_EN
    a_sat_nxt_s  = a_sat_r;
    b_sat_nxt_s  = b_sat_r;
`endif
    case (state_r)
      IDLE: begin
        done_nxt_s = 1'b0;
        if (bus.start) begin
          a_nxt_s      = 16'd0;
          b_nxt_s      = 16'd1;
          cnt_nxt_s    = bus.din;
`ifdef FIB_SATURATE_EN
          a_sat_nxt_s  = 1'b0;
          b_sat_nxt_s  = 1'b0;
`endif
          next_state_s = CALC;
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        // start is deliberately ignored here; the captured index is final.
        if (cnt_r == 16'd0) begin
          dout_nxt_s   = result_s;
          done_nxt_s   = 1'b1;
          next_state_s = DONE;
        end else begin
          a_nxt_s      = b_r;
          b_nxt_s      = sum_s[15:0];
          cnt_nxt_s    = cnt_r - 16'd1;
`ifdef FIB_SATURATE_EN
          a_sat_nxt_s  = b_sat_r;
          b_sat_nxt_s  = a_sat_r | b_sat_r | sum_s[16];
`endif
          next_state_s = CALC;
        end
      end
      DONE: begin
        if (bus.start) begin
          // Back-to-back restart: drop done now, keep the old dout visible.
          done_nxt_s   = 1'b0;
          a_nxt_s      = 16'd0;
          b_nxt_s      = 16'd1;
          cnt_nxt_s    = bus.din;
`ifdef FIB_SATURATE_EN
          a_sat_nxt_s  = 1'b0;
          b_sat_nxt_s  = 1'b0;
`endif
          next_state_s = CALC;
        end else begin
          done_nxt_s   = 1'b1;
          next_state_s = DONE;
        end
      end
      default: begin
        done_nxt_s   = 1'b0;
        next_state_s = IDLE;
      end
    endcase
  end

  // State, datapath and output registers; reset aborts any calculation at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      a_r     <= 16'd0;
      b_r     <= 16'd0;
      cnt_r   <= 16'd0;
      dout_r  <= 16'h0000;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      a_r     <= a_nxt_s;
      b_r     <= b_nxt_s;
      cnt_r   <= cnt_nxt_s;
      dout_r  <= dout_nxt_s;
      done_r  <= done_nxt_s;
    end
  end

`ifdef FIB_SATURATE_EN
  // Sticky overflow flags that travel with a and b through the recurrence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_sat_r <= 1'b0;
      b_sat_r <= 1'b0;
    end else begin
      a_sat_r <= a_sat_nxt_s;
      b_sat_r <= b_sat_nxt_s;
    end
  end
`endif

endmodule

// File: tb/tb_fibonacci_unit.sv
// Directed self-checking bench for fibonacci_unit.
module tb_fibonacci_unit;

  logic        clk;
  logic        reset;
  int          total_checks;
  int          passed_checks;
  logic [15:0] prev_dout;

  fibonacci_unit_if bus ();

  fibonacci_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FIB_SATURATE_EN
  localparam logic [15:0] EXP_F25 = 16'hFFFF;
`else
  localparam logic [15:0] EXP_F25 = 16'd9489;
`endif

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total_checks++;
    if (observed === expected) begin
      passed_checks++;
    end else begin
      $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_dout", {16'd0, bus.dout}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    prev_dout = 16'd0;
  endtask

  // Launch one computation with a single-cycle start, then measure latency and result.
  task automatic run_fib(input logic [15:0] n, input logic [15:0] exp_val, input bit poke);
    int cycles;
    bit seen;
    @(negedge clk);
    bus.din   = n;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.din   = 16'hA5A5;
    check("done_clr", {31'd0, bus.done}, 32'd0);
    check("dout_hold", {16'd0, bus.dout}, {16'd0, prev_dout});
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 200) begin
      if (poke && cycles == 3) begin
        bus.din   = 16'd3;
        bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      cycles++;
      @(negedge clk);
      if (bus.done) begin
        seen = 1'b1;
      end else begin
        check("dout_calc", {16'd0, bus.dout}, {16'd0, prev_dout});
      end
    end
    bus.start = 1'b0;
    check("latency", cycles, {16'd0, n} + 32'd1);
    check("result", {16'd0, bus.dout}, {16'd0, exp_val});
    prev_dout = exp_val;
    repeat (3) @(negedge clk);
    check("done_held", {31'd0, bus.done}, 32'd1);
    check("dout_held", {16'd0, bus.dout}, {16'd0, exp_val});
  endtask

  initial begin
    total_checks  = 0;
    passed_checks = 0;
    prev_dout     = 16'd0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.din       = 16'd0;
    repeat (2) @(negedge clk);
    check("init_done", {31'd0, bus.done}, 32'd0);
    check("init_dout", {16'd0, bus.dout}, 32'd0);
    reset = 1'b1;

    run_fib(16'd5, 16'd5, 1'b0);
    do_reset();
    run_fib(16'd10, 16'd55, 1'b0);
    run_fib(16'd0, 16'd0, 1'b0);
    run_fib(16'd1, 16'd1, 1'b0);
    run_fib(16'd2, 16'd1, 1'b0);
    run_fib(16'd24, 16'd46368, 1'b0);
    run_fib(16'd25, EXP_F25, 1'b0);
    // Restart from DONE without reset, with a stray start during CALC.
    run_fib(16'd7, 16'd13, 1'b1);

    // Reset in the middle of a long calculation.
    @(negedge clk);
    bus.din   = 16'd20;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_dout_old", {16'd0, bus.dout}, 32'd13);
    reset = 1'b0;
    #1;
    check("abort_done", {31'd0, bus.done}, 32'd0);
    check("abort_dout", {16'd0, bus.dout}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    prev_dout = 16'd0;
    repeat (30) @(negedge clk);
    check("idle_done", {31'd0, bus.done}, 32'd0);
    check("idle_dout", {16'd0, bus.dout}, 32'd0);

    run_fib(16'd3, 16'd2, 1'b0);

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule
